uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 88 ++++++++
 rtl/uart_tx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit path: FSM state
//               encoding, default queue depth, default START retry timeout
//               and the bit position of the busy flag in the CPU status word.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DEFAULT_DEPTH         = 8;
    localparam int unsigned DEFAULT_START_TIMEOUT = 15;
    localparam int unsigned BUSY_BIT              = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with power-of-two depth. The head entry is
//               presented combinationally on rd_data. A write while full is
//               accepted only when a read happens in the same cycle;
//               otherwise it is dropped and the queue is left untouched.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               wr_en/wr_data - push request and data
//               rd_en         - pop request (ignored when empty)
//               rd_data       - current head entry
//               full/empty    - derived from the registered occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic w_push;
    logic w_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees the slot this cycle, so a push alongside it is safe even
    // when the queue is full.
    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && (!full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : CPU-side UART transmit controller. Bytes stored by the CPU
//               are queued in a sync_fifo and launched one at a time to the
//               serializer with a single-cycle tx_start pulse. If the
//               serializer does not raise tx_busy within START_TIMEOUT
//               cycles the same byte is launched again.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               uart_write     - CPU data-register store strobe
//               data_from_cpu  - store data, bits [7:0] used
//               uart_busy      - status bit for CPU polling
//               tx_start       - launch pulse to serializer
//               tx_data        - byte under transmission
//               tx_busy        - serializer shifting
//               tx_idle        - queue empty and FSM idle
//               ovf            - sticky drop flag (UART_TX_OVF_EN only)
// Config      : define UART_TX_OVF_EN to add the ovf output; uart_busy then
//               also reports a pending overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_write,
    input  logic [31:0] data_from_cpu,
    output logic        uart_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        tx_idle
`ifdef UART_TX_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

    tx_state_e      state_q,    state_d;
    logic [7:0]     tx_data_q,  tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic [TW-1:0]  timer_q,    timer_d;

    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_head;
    logic [BUSY_BIT:0] w_status;
    logic           w_unused_data;

    assign w_unused_data = ^data_from_cpu[31:8];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (uart_write),
        .wr_data (data_from_cpu[7:0]),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timer_d    = timer_q;
        w_pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    tx_data_d  = w_head;
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tx_busy) begin
                    timer_d = '0;
                    state_d = ST_SEND;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    // Serializer missed the launch: pulse again, byte unchanged.
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timer_q    <= timer_d;
        end
    end

`ifdef UART_TX_OVF_EN
    logic ovf_q, ovf_d;
    logic w_accept;

    assign w_accept = uart_write && (!w_full || w_pop);

    // A rejected write sets the flag; the next write landing in an empty
    // queue marks the CPU as having recovered and clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (uart_write && !w_accept) begin
            ovf_d = 1'b1;
        end else if (w_accept && w_empty) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf                = ovf_q;
    assign w_status[BUSY_BIT] = w_full | ovf_q;
`else
    assign w_status[BUSY_BIT] = w_full;
`endif

    assign uart_busy = w_status[BUSY_BIT];
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign tx_idle   = w_empty && (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Directed testbench for uart_tx_ctrl (DEPTH=8,
//               START_TIMEOUT=15) with a behavioural serializer that can be
//               held busy or told to ignore launch pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic        clk;
    logic        rst_n;
    logic        uart_write;
    logic [31:0] data_from_cpu;
    logic        uart_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_idle;
`ifdef UART_TX_OVF_EN
    logic        ovf;
    localparam logic OVF_BUILD = 1'b1;
`else
    localparam logic OVF_BUILD = 1'b0;
`endif

    uart_tx_ctrl #(
        .DEPTH         (8),
        .START_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_write    (uart_write),
        .data_from_cpu (data_from_cpu),
        .uart_busy     (uart_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .tx_idle       (tx_idle)
`ifdef UART_TX_OVF_EN
        ,
        .ovf           (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- serializer model ----------------
    logic [7:0] emitted [$];
    int  busy_cnt   = 0;
    int  ser_len    = 10;
    int  ser_ignore = 0;
    int  ign_seen   = 0;
    int  start_cnt  = 0;
    bit  ser_hold   = 1'b0;
    bit  prev_start = 1'b0;
    bit  dbl        = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                start_cnt++;
                if (prev_start) dbl = 1'b1;
            end
            prev_start = (tx_start === 1'b1);
            if (tx_busy) begin
                if (busy_cnt > 1) begin
                    busy_cnt--;
                end else if (!ser_hold) begin
                    busy_cnt = 0;
                    tx_busy  = 1'b0;
                end
            end else if (tx_start === 1'b1) begin
                if (ign_seen < ser_ignore) begin
                    ign_seen++;
                end else begin
                    emitted.push_back(tx_data);
                    tx_busy  = 1'b1;
                    busy_cnt = ser_len;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (tx_idle !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, tx_idle}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int s0;
        int e0;

        rst_n         = 1'b0;
        uart_write    = 1'b0;
        data_from_cpu = 32'h0;
        repeat (3) tick();

        chk("rst_idle",   {31'd0, tx_idle},   32'd1);
        chk("rst_busy",   {31'd0, uart_busy}, 32'd0);
        chk("rst_start",  {31'd0, tx_start},  32'd0);
        chk("rst_data",   {24'd0, tx_data},   32'h00);
`ifdef UART_TX_OVF_EN
        chk("rst_ovf",    {31'd0, ovf},       32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte, k+2 latency, 10-cycle serializer.
        base = emitted.size();
        s0   = start_cnt;
        uart_write    = 1'b1;
        data_from_cpu = 32'hDEADBE41;
        tick();
        uart_write = 1'b0;
        chk("lat_k1_start", {31'd0, tx_start}, 32'd0);
        chk("lat_k1_idle",  {31'd0, tx_idle},  32'd0);
        tick();
        chk("lat_k2_start", {31'd0, tx_start}, 32'd1);
        chk("lat_k2_data",  {24'd0, tx_data},  32'h41);
        tick();
        chk("one_cycle_start", {31'd0, tx_start}, 32'd0);
        wait_idle("single_idle", 40);
        chk("single_count", emitted.size() - base, 32'd1);
        chk("single_byte",  {24'd0, emitted[base]}, 32'h41);
        chk("single_starts", start_cnt - s0, 32'd1);

        // Fill the queue behind a held transfer, then overflow it.
        base     = emitted.size();
        ser_hold = 1'b1;
        uart_write    = 1'b1;
        data_from_cpu = 32'h000000AA;
        tick();
        uart_write = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            uart_write    = 1'b1;
            data_from_cpu = 32'(i);
            tick();
            chk("burst_busy", {31'd0, uart_busy}, {31'd0, (i == 7)});
        end
        data_from_cpu = 32'h000000FF;
        tick();
        uart_write = 1'b0;
        chk("drop_busy", {31'd0, uart_busy}, 32'd1);
`ifdef UART_TX_OVF_EN
        chk("drop_ovf",  {31'd0, ovf},       32'd1);
`endif
        repeat (3) tick();
        chk("drop_still_full", {31'd0, uart_busy}, 32'd1);

        // Release the serializer and write exactly on the IDLE pop edge.
        ser_hold = 1'b0;
        tick();
        tick();
        uart_write    = 1'b1;
        data_from_cpu = 32'h00000008;
        chk("pop_edge_nostart", {31'd0, tx_start}, 32'd0);
        tick();
        uart_write = 1'b0;
        chk("pop_push_full",  {31'd0, uart_busy}, 32'd1);
        chk("pop_push_start", {31'd0, tx_start},  32'd1);
        chk("pop_push_head",  {24'd0, tx_data},   32'h00);
        wait_idle("drain_idle", 400);
        chk("drain_count", emitted.size() - base, 32'd10);
        chk("drain_first", {24'd0, emitted[base]}, 32'hAA);
        for (int i = 0; i < 9; i++) begin
            chk("drain_order", {24'd0, emitted[base + 1 + i]}, 32'(i));
        end
        chk("drain_busy", {31'd0, uart_busy}, {31'd0, OVF_BUILD});

        // A write into the empty queue clears a pending overflow.
        uart_write    = 1'b1;
        data_from_cpu = 32'h00000055;
        tick();
        uart_write = 1'b0;
        chk("recover_busy", {31'd0, uart_busy}, 32'd0);
`ifdef UART_TX_OVF_EN
        chk("recover_ovf",  {31'd0, ovf},       32'd0);
`endif
        wait_idle("recover_idle", 40);

        // Serializer ignores the first launch; retry 15 cycles later.
        base       = emitted.size();
        s0         = start_cnt;
        ser_ignore = ign_seen + 1;
        uart_write    = 1'b1;
        data_from_cpu = 32'h0000005A;
        tick();
        uart_write = 1'b0;
        tick();
        chk("retry_first",  {31'd0, tx_start}, 32'd1);
        repeat (14) tick();
        chk("retry_early",  {31'd0, tx_start}, 32'd0);
        tick();
        chk("retry_second", {31'd0, tx_start}, 32'd1);
        chk("retry_data",   {24'd0, tx_data},  32'h5A);
        wait_idle("retry_idle", 40);
        chk("retry_count",  emitted.size() - base, 32'd1);
        chk("retry_byte",   {24'd0, emitted[base]}, 32'h5A);
        chk("retry_starts", start_cnt - s0, 32'd2);

        // Reset while one byte is in flight and three are queued.
        ser_len       = 20;
        uart_write    = 1'b1;
        data_from_cpu = 32'h00000011;
        tick();
        uart_write = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            uart_write    = 1'b1;
            data_from_cpu = 32'h22 + 32'(i) * 32'h11;
            tick();
        end
        uart_write = 1'b0;
        chk("mid_not_idle", {31'd0, tx_idle}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idle",  {31'd0, tx_idle},   32'd1);
        chk("mid_rst_busy",  {31'd0, uart_busy}, 32'd0);
        chk("mid_rst_start", {31'd0, tx_start},  32'd0);
        chk("mid_rst_data",  {24'd0, tx_data},   32'h00);
        s0 = start_cnt;
        e0 = emitted.size();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("post_rst_starts", start_cnt - s0, 32'd0);
        chk("post_rst_bytes",  emitted.size() - e0, 32'd0);
        chk("post_rst_idle",   {31'd0, tx_idle}, 32'd1);

        chk("start_never_double", {31'd0, dbl}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
